// File: rtl/wait_state_memory.sv
// ============================================================================
// Module   : wait_state_memory
// Brief    : Single-port 32-bit word memory with fixed read/write wait states
//            and byte-lane write masks. Optional macro MEM_ERR_EN adds
//            out-of-range detection and the mem_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_state_memory #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    RD_WAIT     = 2,
    parameter int    WR_WAIT     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        mem_wbusy
`ifdef MEM_ERR_EN
    ,
    output logic        mem_err
`endif
);

    localparam int         c_aw     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_rd_cnt = 4'(RD_WAIT);
    localparam logic [3:0] c_wr_cnt = 4'(WR_WAIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [c_aw-1:0]   r_idx;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic [c_aw-1:0]   w_idx;
    logic              w_idle;
    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_oob;
    logic              w_wr_now;
    logic              w_wr_late;
    logic              w_commit;
    logic [c_aw-1:0]   w_cm_idx;
    logic [31:0]       w_cm_data;
    logic [3:0]        w_cm_mask;
    logic              w_rd_now;
    logic              w_rd_late;
    logic [c_aw-1:0]   w_rd_idx;
    logic              w_unused_addr;

    assign w_idx         = mem_addr[2 +: c_aw];
    assign w_unused_addr = ^{mem_addr[1:0], mem_addr[31:2+c_aw]};

    // Writes take priority over a simultaneous read strobe.
    assign w_idle   = (r_state == S_IDLE);
    assign w_wr_req = w_idle && (mem_wmask != 4'h0);
    assign w_rd_req = w_idle && mem_rstrb && (mem_wmask == 4'h0);

`ifdef MEM_ERR_EN
    localparam logic [29:0] c_depth = 30'(DEPTH_WORDS);
    logic r_err;

    assign w_oob   = (mem_addr[31:2] >= c_depth);
    assign mem_err = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_wr_req || w_rd_req) && w_oob;
        end
    end
`else
    assign w_oob = 1'b0;
`endif

    // Zero-wait accesses complete on the request edge using live inputs;
    // delayed accesses complete when the counter reaches one, using latched values.
    assign w_wr_now  = w_wr_req && !w_oob && (WR_WAIT == 0);
    assign w_wr_late = (r_state == S_WR_WAIT) && (r_cnt == 4'd1);
    assign w_commit  = !reset && (w_wr_now || w_wr_late);
    assign w_cm_idx  = w_wr_late ? r_idx   : w_idx;
    assign w_cm_data = w_wr_late ? r_wdata : mem_wdata;
    assign w_cm_mask = w_wr_late ? r_wmask : mem_wmask;

    assign w_rd_now  = w_rd_req && !w_oob && (RD_WAIT == 0);
    assign w_rd_late = (r_state == S_RD_WAIT) && (r_cnt == 4'd1);
    assign w_rd_idx  = w_rd_late ? r_idx : w_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_wr_req && !w_oob && (WR_WAIT != 0)) begin
                    w_state_nxt = S_WR_WAIT;
                    w_cnt_nxt   = c_wr_cnt;
                end else if (w_rd_req && !w_oob && (RD_WAIT != 0)) begin
                    w_state_nxt = S_RD_WAIT;
                    w_cnt_nxt   = c_rd_cnt;
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_req) begin
            r_idx   <= w_idx;
            r_wdata <= mem_wdata;
            r_wmask <= mem_wmask;
        end else if (w_rd_req) begin
            r_idx   <= w_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0;
        end else if (w_rd_req && w_oob) begin
            r_rdata <= 32'h0;
        end else if (w_rd_now || w_rd_late) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    // Array is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_cm_mask[b]) begin
                    r_mem[w_cm_idx][8*b +: 8] <= w_cm_data[8*b +: 8];
                end
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_rbusy = (r_state == S_RD_WAIT);
    assign mem_wbusy = (r_state == S_WR_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_wait_state_memory.sv
// ============================================================================
// Module   : tb_wait_state_memory
// Brief    : Directed bench: zero-wait instance driven from a vector table,
//            multi-wait instance exercised with hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wait_state_memory;

`ifdef MEM_ERR_EN
    localparam bit c_err_on = 1'b1;
`else
    localparam bit c_err_on = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_rstrb, a_rbusy, a_wbusy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wmask;
    logic        b_rst, b_rstrb, b_rbusy, b_wbusy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wmask;
`ifdef MEM_ERR_EN
    logic        a_err, b_err;
`endif

    wait_state_memory #(.DEPTH_WORDS(256), .RD_WAIT(2), .WR_WAIT(3), .INIT_FILE("")) u_dut_a (
        .clk(clk), .reset(a_rst), .mem_addr(a_addr), .mem_rstrb(a_rstrb),
        .mem_rdata(a_rdata), .mem_rbusy(a_rbusy), .mem_wdata(a_wdata),
        .mem_wmask(a_wmask), .mem_wbusy(a_wbusy)
`ifdef MEM_ERR_EN
        , .mem_err(a_err)
`endif
    );

    wait_state_memory #(.DEPTH_WORDS(256), .RD_WAIT(0), .WR_WAIT(0), .INIT_FILE("")) u_dut_b (
        .clk(clk), .reset(b_rst), .mem_addr(b_addr), .mem_rstrb(b_rstrb),
        .mem_rdata(b_rdata), .mem_rbusy(b_rbusy), .mem_wdata(b_wdata),
        .mem_wmask(b_wmask), .mem_wbusy(b_wbusy)
`ifdef MEM_ERR_EN
        , .mem_err(b_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rstrb;
        logic [3:0]  wmask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic a_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        int n;
        @(negedge clk);
        a_addr = addr; a_wdata = data; a_wmask = mask;
        @(posedge clk); #1;
        a_wmask = 4'h0;
        n = 0;
        while (a_wbusy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_wr_busy_cycles", 32'(n), 32'd3);
    endtask

    task automatic a_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        int n;
        @(negedge clk);
        a_addr = addr; a_rstrb = 1'b1;
        @(posedge clk); #1;
        a_rstrb = 1'b0;
        n = 0;
        while (a_rbusy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_rd_busy_cycles", 32'(n), 32'd2);
        check(name, a_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic rb_seen;

        a_rst = 1'b1; a_rstrb = 1'b0; a_addr = '0; a_wdata = '0; a_wmask = '0;
        b_rst = 1'b1; b_rstrb = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '0;

        //            rstrb wmask  addr          wdata          exp_rdata                                 err
        vecs[0]  = '{1'b0, 4'hF, 32'h0000_0000, 32'hA0A0_A0A0, 32'h0,                                     1'b0};
        vecs[1]  = '{1'b0, 4'hF, 32'h0000_0004, 32'h0000_1111, 32'h0,                                     1'b0};
        vecs[2]  = '{1'b0, 4'hF, 32'h0000_0008, 32'h2222_2222, 32'h0,                                     1'b0};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         32'hA0A0_A0A0,                             1'b0};
        vecs[4]  = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,         32'h0000_1111,                             1'b0};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,         32'h2222_2222,                             1'b0};
        vecs[6]  = '{1'b0, 4'h3, 32'h0000_0004, 32'hFFFF_ABCD, 32'h2222_2222,                             1'b0};
        vecs[7]  = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,         32'h0000_ABCD,                             1'b0};
        vecs[8]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h0000_ABCD,                             1'b0};
        vecs[9]  = '{1'b0, 4'hF, 32'h0000_0400, 32'h5555_5555, 32'h0000_ABCD,                             c_err_on};
        vecs[10] = '{1'b1, 4'hF, 32'h0000_0020, 32'h0000_0077, 32'h0000_ABCD,                             1'b0};
        vecs[11] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         c_err_on ? 32'hA0A0_A0A0 : 32'h5555_5555,  1'b0};
        vecs[12] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'h0000_0077,                             1'b0};
        vecs[13] = '{1'b1, 4'h0, 32'h0000_0003, 32'h0,         c_err_on ? 32'hA0A0_A0A0 : 32'h5555_5555,  1'b0};
        vecs[14] = '{1'b1, 4'h0, 32'h0000_0404, 32'h0,         c_err_on ? 32'h0 : 32'h0000_ABCD,          c_err_on};
        vecs[15] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         c_err_on ? 32'h0 : 32'h0000_ABCD,          1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("a_reset_rdata", a_rdata, 32'h0);
        check("a_reset_rbusy", 32'(a_rbusy), 32'd0);
        check("a_reset_wbusy", 32'(a_wbusy), 32'd0);
        check("b_reset_rdata", b_rdata, 32'h0);
`ifdef MEM_ERR_EN
        check("b_reset_err", 32'(b_err), 32'd0);
`endif
        @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;

        // Zero-wait instance: every access completes on its request edge.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b_rstrb = vecs[i].rstrb; b_wmask = vecs[i].wmask;
            b_addr  = vecs[i].addr;  b_wdata = vecs[i].wdata;
            @(posedge clk); #1;
            check($sformatf("b_vec%0d_rdata", i), b_rdata, vecs[i].exp_rdata);
            check($sformatf("b_vec%0d_rbusy", i), 32'(b_rbusy), 32'd0);
            check($sformatf("b_vec%0d_wbusy", i), 32'(b_wbusy), 32'd0);
`ifdef MEM_ERR_EN
            check($sformatf("b_vec%0d_err", i), 32'(b_err), 32'(vecs[i].exp_err));
`endif
        end
        @(negedge clk);
        b_rstrb = 1'b0; b_wmask = 4'h0;

        // Partial byte-lane writes merge into an existing word.
        a_write(32'h40, 32'h1122_3344, 4'hF);
        a_write(32'h40, 32'h0000_00AA, 4'b0001);
        a_write(32'h40, 32'h00BB_0000, 4'b0100);
        a_read(32'h40, 32'h11BB_33AA, "a_merge_rdata");

        // Read with wait states; inputs changed mid-wait must be ignored.
        a_write(32'h100, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        a_addr = 32'h100; a_rstrb = 1'b1;
        @(posedge clk); #1;
        check("a_rd_wait1_rbusy", 32'(a_rbusy), 32'd1);
        a_addr = 32'h40; a_wmask = 4'hF; a_wdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        check("a_rd_wait2_rbusy", 32'(a_rbusy), 32'd1);
        check("a_rd_wait2_rdata_held", a_rdata, 32'h11BB_33AA);
        @(posedge clk); #1;
        a_wmask = 4'h0; a_rstrb = 1'b0;
        check("a_rd_done_rbusy", 32'(a_rbusy), 32'd0);
        check("a_rd_done_wbusy", 32'(a_wbusy), 32'd0);
        check("a_rd_done_rdata", a_rdata, 32'hDEAD_BEEF);
        a_read(32'h40, 32'h11BB_33AA, "a_ignored_write_rdata");

        // Simultaneous strobe and write: write wins, read dropped.
        @(negedge clk);
        a_addr = 32'h20; a_rstrb = 1'b1; a_wmask = 4'hF; a_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        a_rstrb = 1'b0; a_wmask = 4'h0;
        check("a_both_wbusy", 32'(a_wbusy), 32'd1);
        rb_seen = a_rbusy;
        n = 0;
        while (a_wbusy && n < 20) begin
            @(posedge clk); #1;
            rb_seen = rb_seen | a_rbusy;
            n++;
        end
        check("a_both_wr_cycles", 32'(n), 32'd3);
        check("a_both_rbusy_seen", 32'(rb_seen), 32'd0);
        check("a_both_rdata_held", a_rdata, 32'h11BB_33AA);
        a_read(32'h20, 32'h1234_5678, "a_both_rdata");

        // Reset during the second write wait cycle discards the write.
        a_write(32'h8, 32'hCAFE_0008, 4'hF);
        @(negedge clk);
        a_addr = 32'h8; a_wdata = 32'h5; a_wmask = 4'hF;
        @(posedge clk); #1;
        a_wmask = 4'h0;
        check("a_wrst_wbusy1", 32'(a_wbusy), 32'd1);
        @(posedge clk); #1;
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        check("a_wrst_wbusy_after", 32'(a_wbusy), 32'd0);
        check("a_wrst_rdata", a_rdata, 32'h0);
        a_read(32'h8, 32'hCAFE_0008, "a_wrst_prior_value");

        // Reset during a read wait; the write presented in the reset cycle is ignored.
        @(negedge clk);
        a_addr = 32'h8; a_rstrb = 1'b1;
        @(posedge clk); #1;
        check("a_rrst_rbusy1", 32'(a_rbusy), 32'd1);
        a_rstrb = 1'b0; a_rst = 1'b1; a_wmask = 4'hF; a_wdata = 32'h99;
        @(posedge clk); #1;
        a_rst = 1'b0; a_wmask = 4'h0;
        check("a_rrst_rbusy", 32'(a_rbusy), 32'd0);
        check("a_rrst_wbusy", 32'(a_wbusy), 32'd0);
        check("a_rrst_rdata", a_rdata, 32'h0);
        a_read(32'h8, 32'hCAFE_0008, "a_rrst_mem_kept");

`ifdef MEM_ERR_EN
        // Out-of-range write: no wait states, one-cycle error pulse.
        @(negedge clk);
        a_addr = 32'h400; a_wdata = 32'hFFFF_FFFF; a_wmask = 4'hF;
        @(posedge clk); #1;
        a_wmask = 4'h0;
        check("a_oob_err", 32'(a_err), 32'd1);
        check("a_oob_wbusy", 32'(a_wbusy), 32'd0);
        @(posedge clk); #1;
        check("a_oob_err_clear", 32'(a_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
